msb_watch: RTL and testbench

Parametrised successor to the team's single-bit clocked flag register: watches one selected bit of a W-bit input bus, drives a registered (optionally inverted), debounced copy of it, and emits edge pulses plus a saturating toggle count. Used in the lab test benches and small datapaths wherever a bus flag must be sampled cleanly on `clk` instead of glitching through combinational logic.

---
 rtl/msb_watch_pkg.sv | 16 +
 rtl/msb_watch_if.sv | 16 +
 rtl/msb_watch_stab_filter.sv | 47 ++++
 rtl/msb_watch.sv | 63 ++++++
 tb/tb_msb_watch.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/msb_watch_pkg.sv
// Shared types for msb_watch: edge classification of a filtered flag change.
package msb_watch_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  // New flag value after an accepted change decides the edge direction.
  function automatic edge_e edge_of(input logic chg, input logic new_val);
    if (!chg) return EDGE_NONE;
    return new_val ? EDGE_RISE : EDGE_FALL;
  endfunction

endpackage

// File: rtl/msb_watch_if.sv
// Bus-side signals of msb_watch: controls and observed bus in, filtered flag out.
interface msb_watch_if #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 8
);
  logic          en;
  logic          clr;
  logic [0:W-1]  a;
  logic          x;
  logic          x_rise;
  logic          x_fall;
  logic [CW-1:0] toggles;

  modport master (output en, clr, a, input x, x_rise, x_fall, toggles);
  modport slave  (input en, clr, a, output x, x_rise, x_fall, toggles);
endinterface

// File: rtl/msb_watch_stab_filter.sv
// Debounce filter: x follows candidate c only after DEPTH consecutive differing samples.
module stab_filter #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned SW    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic c,
  output logic x,
  output logic chg_c
);

  logic [SW-1:0] stab_q, stab_d;
  logic          x_q, x_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q    <= 1'b0;
      stab_q <= '0;
    end else begin
      x_q    <= x_d;
      stab_q <= stab_d;
    end
  end

  // Accept on the DEPTH-th consecutive mismatch; any match restarts the count.
  always_comb begin
    x_d    = x_q;
    stab_d = stab_q;
    chg_c  = 1'b0;
    if (en) begin
      if (c == x_q) begin
        stab_d = '0;
      end else if (stab_q == SW'(DEPTH - 1)) begin
        x_d    = c;
        stab_d = '0;
        chg_c  = 1'b1;
      end else begin
        stab_d = stab_q + SW'(1);
      end
    end
  end

  assign x = x_q;

endmodule

// File: rtl/msb_watch.sv
// Watches one bit of a bus, debounces it, and reports edges plus a saturating toggle count.
module msb_watch
  import msb_watch_pkg::*;
#(
  parameter int unsigned W      = 4,
  parameter int unsigned SEL    = 0,
  parameter int unsigned INVERT = 1,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned CW     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  msb_watch_if.slave   bus
);

  localparam int unsigned SW = $clog2(DEPTH) + 1;

  logic          c_c;
  logic          chg_c;
  logic          x_w;
  edge_e         edge_c;
  logic          x_rise_q;
  logic          x_fall_q;
  logic [CW-1:0] tog_q;

  assign c_c    = (INVERT != 0) ? ~bus.a[SEL] : bus.a[SEL];
  assign edge_c = edge_of(chg_c, c_c);

  stab_filter #(
    .DEPTH (DEPTH),
    .SW    (SW)
  ) u_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .c     (c_c),
    .x     (x_w),
    .chg_c (chg_c)
  );

  // Pulses and counter; clr is honoured regardless of en and beats an increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_rise_q <= 1'b0;
      x_fall_q <= 1'b0;
      tog_q    <= '0;
    end else begin
      x_rise_q <= (edge_c == EDGE_RISE);
      x_fall_q <= (edge_c == EDGE_FALL);
      if (bus.clr) begin
        tog_q <= '0;
      end else if (chg_c && (tog_q != '1)) begin
        tog_q <= tog_q + CW'(1);
      end
    end
  end

  assign bus.x       = x_w;
  assign bus.x_rise  = x_rise_q;
  assign bus.x_fall  = x_fall_q;
  assign bus.toggles = tog_q;

endmodule

// File: tb/tb_msb_watch.sv
// Randomised check of four msb_watch configurations against a sample-history model.
module tb_msb_watch;

  logic clk;
  logic rst_n;
  logic en;
  logic clr [4];
  logic [0:7] av [4];

  int errors = 0;
  int checks = 0;

  // Per-instance configuration: DEPTH, SEL, INVERT, CW.
  int dep [4] = '{1, 3, 2, 4};
  int sel [4] = '{0, 0, 5, 2};
  int inv [4] = '{1, 1, 0, 1};
  int cwv [4] = '{8, 8, 2, 8};

  // Model state: flag, recent enabled candidates (bit 0 newest), valid count.
  logic       xm   [4];
  logic       rm   [4];
  logic       fm   [4];
  int         tm   [4];
  logic [7:0] hist [4];
  int         nh   [4];

  msb_watch_if #(.W(4), .CW(8)) if0 ();
  msb_watch_if #(.W(4), .CW(8)) if1 ();
  msb_watch_if #(.W(8), .CW(2)) if2 ();
  msb_watch_if #(.W(4), .CW(8)) if3 ();

  msb_watch #(.W(4), .SEL(0), .INVERT(1), .DEPTH(1), .CW(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  msb_watch #(.W(4), .SEL(0), .INVERT(1), .DEPTH(3), .CW(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  msb_watch #(.W(8), .SEL(5), .INVERT(0), .DEPTH(2), .CW(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  msb_watch #(.W(4), .SEL(2), .INVERT(1), .DEPTH(4), .CW(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic cand(input int id);
    logic [0:7] v;
    v = av[id];
    return (inv[id] != 0) ? ~v[sel[id]] : v[sel[id]];
  endfunction

  // x changes once the last DEPTH enabled candidates all disagree with it.
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      logic c;
      bit   fire;
      int   maxv;
      maxv = (1 << cwv[i]) - 1;
      if (!rst_n) begin
        xm[i] = 1'b0; rm[i] = 1'b0; fm[i] = 1'b0; tm[i] = 0;
        hist[i] = '0; nh[i] = 0;
      end else begin
        rm[i] = 1'b0; fm[i] = 1'b0;
        fire = 1'b0;
        if (en) begin
          c = cand(i);
          hist[i] = {hist[i][6:0], c};
          nh[i]++;
          if (nh[i] >= dep[i]) begin
            fire = 1'b1;
            for (int k = 0; k < dep[i]; k++)
              if (hist[i][k] == xm[i]) fire = 1'b0;
          end
          if (fire) begin
            xm[i] = c;
            rm[i] = c;
            fm[i] = ~c;
            nh[i] = 0;
          end
        end
        if (clr[i]) tm[i] = 0;
        else if (fire && tm[i] < maxv) tm[i]++;
      end
    end
  endtask

  task automatic chk_dut(input int id, input logic x, input logic r, input logic f, input logic [7:0] t);
    chk($sformatf("d%0d.x", id), 8'(x), 8'(xm[id]));
    chk($sformatf("d%0d.x_rise", id), 8'(r), 8'(rm[id]));
    chk($sformatf("d%0d.x_fall", id), 8'(f), 8'(fm[id]));
    chk($sformatf("d%0d.toggles", id), t, 8'(tm[id]));
  endtask

  task automatic tick();
    if0.en = en; if1.en = en; if2.en = en; if3.en = en;
    if0.clr = clr[0]; if1.clr = clr[1]; if2.clr = clr[2]; if3.clr = clr[3];
    if0.a = av[0][0:3];
    if1.a = av[1][0:3];
    if2.a = av[2];
    if3.a = av[3][0:3];
    @(posedge clk);
    model_edge();
    #1;
    chk_dut(0, if0.x, if0.x_rise, if0.x_fall, 8'(if0.toggles));
    chk_dut(1, if1.x, if1.x_rise, if1.x_fall, 8'(if1.toggles));
    chk_dut(2, if2.x, if2.x_rise, if2.x_fall, 8'(if2.toggles));
    chk_dut(3, if3.x, if3.x_rise, if3.x_fall, 8'(if3.toggles));
  endtask

  initial begin
    logic [0:7] m;
    rst_n = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clr[i] = 1'b0;
      av[i]  = 8'($urandom);
      xm[i] = 1'b0; rm[i] = 1'b0; fm[i] = 1'b0; tm[i] = 0; hist[i] = '0; nh[i] = 0;
    end
    @(negedge clk);
    tick();
    tick();

    // First edge after reset with a=0: inverted DEPTH=1 flag rises immediately.
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) av[i] = 8'h00;
    tick();
    chk("d0.first_x", 8'(if0.x), 8'd1);
    chk("d0.first_rise", 8'(if0.x_rise), 8'd1);
    chk("d0.first_toggles", 8'(if0.toggles), 8'd1);
    tick();
    tick();
    chk("d1.depth3_x", 8'(if1.x), 8'd1);
    chk("d1.depth3_rise", 8'(if1.x_rise), 8'd1);

    // Two-cycle glitch on a DEPTH=3 flag must not propagate.
    av[1] = 8'h80;
    tick();
    tick();
    av[1] = 8'h00;
    tick();
    chk("d1.glitch_x", 8'(if1.x), 8'd1);
    chk("d1.glitch_toggles", 8'(if1.toggles), 8'd1);

    // Enable frozen for 5 cycles while the bus toggles.
    en = 1'b0;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 4; i++) av[i] = ~av[i];
      tick();
    end
    en = 1'b1;

    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      en    = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < 4; i++) begin
        clr[i] = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 4) == 0) av[i] = 8'($urandom);
      end
      // Unwatched bits of the SEL=5 instance churn freely.
      m = 8'($urandom);
      m[5] = 1'b0;
      av[2] = av[2] ^ m;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
